// File: rtl/pc_seq.sv
// Program counter sequencer: holds the architectural PC, resolves branch/call/return
// each time pc_write pulses, and keeps a small hardware return-address stack.
module pc_seq #(
  parameter int STK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        pc_write,
  input  logic [15:0] br_addr,
  input  logic        br_req,
  input  logic [3:0]  br_cond,
  input  logic [3:0]  cc,
  input  logic        call_req,
  input  logic        ret_req,
  output logic [15:0] pc_out,
  output logic        br_taken,
  output logic [2:0]  stk_depth,
  output logic        stk_ovf,
  output logic        stk_unf
);

  localparam int AW = $clog2(STK_DEPTH);
  localparam int DW = $clog2(STK_DEPTH + 1);

  logic [15:0]   pc_reg, pc_next;
  logic [DW-1:0] depth_reg, depth_next;
  logic          taken_reg, taken_next;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;

  logic [15:0]   stk_mem [STK_DEPTH];
  logic          push_en;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;
  logic [15:0]   pc_inc;
  logic          take;

  assign pc_inc   = pc_reg + 16'd1;
  assign take     = br_req & ((br_cond == 4'd0) | (|(br_cond & cc)));
  assign push_idx = depth_reg[AW-1:0];
  // Wraps to the last entry when the stack is full, which is exactly the top.
  assign top_idx  = depth_reg[AW-1:0] - AW'(1);

  always_comb begin
    pc_next    = pc_reg;
    depth_next = depth_reg;
    taken_next = 1'b0;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    push_en    = 1'b0;
    if (pc_write) begin
      if (ret_req) begin
        if (depth_reg != '0) begin
          pc_next    = stk_mem[top_idx];
          depth_next = depth_reg - DW'(1);
          taken_next = 1'b1;
        end else begin
          pc_next  = pc_inc;
          unf_next = 1'b1;
        end
      end else if (call_req) begin
        pc_next    = br_addr;
        taken_next = 1'b1;
        if (depth_reg < DW'(STK_DEPTH)) begin
          push_en    = 1'b1;
          depth_next = depth_reg + DW'(1);
        end else begin
          ovf_next = 1'b1;
        end
      end else if (take) begin
        pc_next    = br_addr;
        taken_next = 1'b1;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_reg    <= 16'h0000;
      depth_reg <= '0;
      taken_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      depth_reg <= depth_next;
      taken_reg <= taken_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Stack contents need no reset; only entries below depth are ever read.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stk_mem[push_idx] <= pc_inc;
    end
  end

  assign pc_out    = pc_reg;
  assign br_taken  = taken_reg;
  assign stk_depth = 3'(depth_reg);
  assign stk_ovf   = ovf_reg;
  assign stk_unf   = unf_reg;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios followed by randomized traffic,
// all compared against a queue-based return-stack model.
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        pc_write = 1'b0;
  logic [15:0] br_addr = 16'h0000;
  logic        br_req = 1'b0;
  logic [3:0]  br_cond = 4'h0;
  logic [3:0]  cc = 4'h0;
  logic        call_req = 1'b0;
  logic        ret_req = 1'b0;
  logic [15:0] pc_out;
  logic        br_taken;
  logic [2:0]  stk_depth;
  logic        stk_ovf;
  logic        stk_unf;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  logic        m_taken, m_ovf, m_unf;

  pc_seq #(.STK_DEPTH(4)) dut (
    .clk(clk), .rst_f(rst_f), .pc_write(pc_write), .br_addr(br_addr),
    .br_req(br_req), .br_cond(br_cond), .cc(cc), .call_req(call_req),
    .ret_req(ret_req), .pc_out(pc_out), .br_taken(br_taken),
    .stk_depth(stk_depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_q.delete();
    m_taken = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_update(input bit pw, input bit brq, input logic [3:0] cond,
                              input logic [3:0] c, input bit call, input bit ret,
                              input logic [15:0] addr);
    bit take;
    take = brq && ((cond == 4'd0) || ((cond & c) != 4'd0));
    m_taken = 1'b0;
    if (pw) begin
      if (ret) begin
        if (m_q.size() > 0) begin
          m_pc = m_q.pop_back();
          m_taken = 1'b1;
        end else begin
          m_pc = m_pc + 16'd1;
          m_unf = 1'b1;
        end
      end else if (call) begin
        if (m_q.size() < 4) m_q.push_back(m_pc + 16'd1);
        else m_ovf = 1'b1;
        m_pc = addr;
        m_taken = 1'b1;
      end else if (take) begin
        m_pc = addr;
        m_taken = 1'b1;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".pc"}, pc_out, m_pc);
    chk({ctx, ".taken"}, 16'(br_taken), 16'(m_taken));
    chk({ctx, ".depth"}, 16'(stk_depth), 16'(m_q.size()));
    chk({ctx, ".ovf"}, 16'(stk_ovf), 16'(m_ovf));
    chk({ctx, ".unf"}, 16'(stk_unf), 16'(m_unf));
  endtask

  // One clock of stimulus: drive, advance the model, sample 1 time unit after the edge.
  task automatic step(input string ctx, input bit pw, input bit brq, input logic [3:0] cond,
                      input logic [3:0] c, input bit call, input bit ret,
                      input logic [15:0] addr);
    pc_write = pw; br_req = brq; br_cond = cond; cc = c;
    call_req = call; ret_req = ret; br_addr = addr;
    model_update(pw, brq, cond, c, call, ret, addr);
    @(posedge clk);
    #1;
    $display("step %s pw=%0b br=%0b cond=%h cc=%h call=%0b ret=%0b addr=%h -> pc=%h taken=%0b depth=%0d ovf=%0b unf=%0b",
             ctx, pw, brq, cond, c, call, ret, addr, pc_out, br_taken, stk_depth, stk_ovf, stk_unf);
    check_all(ctx);
  endtask

  task automatic jump(input logic [15:0] addr);
    step("jump", 1, 1, 4'h0, 4'h0, 0, 0, addr);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1, 0, 4'h0, 4'h0, 0, 0, 16'h0000);
  endtask

  task automatic async_reset(input string ctx);
    rst_f = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    chk({ctx, ".pc_zero"}, pc_out, 16'h0000);
    #2;
    rst_f = 1'b1;
  endtask

  initial begin
    model_reset();
    // Power-on reset
    #2;
    chk("reset.pc", pc_out, 16'h0000);
    chk("reset.taken", 16'(br_taken), 16'h0);
    chk("reset.depth", 16'(stk_depth), 16'h0);
    chk("reset.flags", {14'h0, stk_ovf, stk_unf}, 16'h0);
    #1;
    rst_f = 1'b1;

    idle("seq1"); chk("seq1.lit", pc_out, 16'h0001);
    idle("seq2"); chk("seq2.lit", pc_out, 16'h0002);
    idle("seq3"); chk("seq3.lit", pc_out, 16'h0003);
    chk("seq3.taken_lit", 16'(br_taken), 16'h0);

    // Asynchronous reset between edges, with pc_write held high
    pc_write = 1'b1;
    async_reset("midreset");
    pc_write = 1'b0;

    // Conditional branch: not taken, then taken; unconditional via jump
    jump(16'h0010);
    chk("uncond.lit", pc_out, 16'h0010);
    step("cond_nt", 1, 1, 4'b0001, 4'b0000, 0, 0, 16'h0040);
    chk("cond_nt.lit", pc_out, 16'h0011);
    jump(16'h0010);
    step("cond_t", 1, 1, 4'b0001, 4'b0001, 0, 0, 16'h0040);
    chk("cond_t.lit", pc_out, 16'h0040);
    chk("cond_t.taken_lit", 16'(br_taken), 16'h1);

    // Single call / return
    jump(16'h0005);
    step("call1", 1, 0, 4'h0, 4'h0, 1, 0, 16'h0100);
    chk("call1.depth_lit", 16'(stk_depth), 16'h1);
    step("ret1", 1, 0, 4'h0, 4'h0, 0, 1, 16'h0000);
    chk("ret1.lit", pc_out, 16'h0006);

    // Nested calls to overflow, then drain to underflow
    jump(16'h0001);
    step("ncall1", 1, 0, 4'h0, 4'h0, 1, 0, 16'h0101);
    step("ncall2", 1, 0, 4'h0, 4'h0, 1, 0, 16'h0201);
    step("ncall3", 1, 0, 4'h0, 4'h0, 1, 0, 16'h0301);
    step("ncall4", 1, 0, 4'h0, 4'h0, 1, 0, 16'h0401);
    step("ncall5", 1, 0, 4'h0, 4'h0, 1, 0, 16'h0501);
    chk("ovf.depth_lit", 16'(stk_depth), 16'h4);
    chk("ovf.flag_lit", 16'(stk_ovf), 16'h1);
    step("nret1", 1, 0, 4'h0, 4'h0, 0, 1, 16'h0000); chk("nret1.lit", pc_out, 16'h0302);
    step("nret2", 1, 0, 4'h0, 4'h0, 0, 1, 16'h0000); chk("nret2.lit", pc_out, 16'h0202);
    step("nret3", 1, 0, 4'h0, 4'h0, 0, 1, 16'h0000); chk("nret3.lit", pc_out, 16'h0102);
    step("nret4", 1, 0, 4'h0, 4'h0, 0, 1, 16'h0000); chk("nret4.lit", pc_out, 16'h0002);
    step("nret5", 1, 0, 4'h0, 4'h0, 0, 1, 16'h0000); chk("nret5.lit", pc_out, 16'h0003);
    chk("unf.flag_lit", 16'(stk_unf), 16'h1);
    chk("unf.taken_lit", 16'(br_taken), 16'h0);

    // Wrap-around of PC+1 and of the pushed return address
    jump(16'hFFFF);
    idle("wrap");
    chk("wrap.lit", pc_out, 16'h0000);
    jump(16'hFFFF);
    step("wcall", 1, 0, 4'h0, 4'h0, 1, 0, 16'h0200);
    step("wret", 1, 0, 4'h0, 4'h0, 0, 1, 16'h0000);
    chk("wret.lit", pc_out, 16'h0000);

    // Hold with pc_write low while requests toggle
    step("hcall", 1, 0, 4'h0, 4'h0, 1, 0, 16'h0123);
    step("hold1", 0, 1, 4'h0, 4'h0, 0, 0, 16'h0777);
    chk("hold1.taken_lit", 16'(br_taken), 16'h0);
    chk("hold1.pc_lit", pc_out, 16'h0123);
    step("hold2", 0, 0, 4'h0, 4'h0, 1, 0, 16'h0888);
    step("hold3", 0, 0, 4'h0, 4'h0, 0, 1, 16'h0999);
    step("hold4", 0, 1, 4'h0, 4'h0, 1, 1, 16'h0aaa);

    // call_req + ret_req together at depth 1 -> return only
    step("both", 1, 1, 4'h0, 4'h0, 1, 1, 16'h0bbb);
    chk("both.depth_lit", 16'(stk_depth), 16'h0);
    chk("both.pc_lit", pc_out, 16'h0001);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit pw, brq, call, ret;
      logic [3:0] cond, c;
      logic [15:0] addr;
      if ($urandom_range(0, 63) == 0) async_reset("rnd_reset");
      pw   = ($urandom_range(0, 3) != 0);
      brq  = $urandom_range(0, 1) == 1;
      call = ($urandom_range(0, 3) == 0);
      ret  = ($urandom_range(0, 3) == 0);
      cond = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      c    = 4'($urandom_range(0, 15));
      addr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step("rnd", pw, brq, cond, c, call, ret, addr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
